// File: rtl/reg_bank_2r2w.sv
// Two-read / two-write register bank with write port B taking priority on
// same-address collisions, optional same-cycle write forwarding to the read ports.
module reg_bank_2r2w #(
  parameter int unsigned          WORD_SIZE = 16,
  parameter int unsigned          ADDR_W    = 4,
  parameter int unsigned          NUM_REGS  = 12,
  parameter int unsigned          BYPASS    = 1,
  parameter logic [WORD_SIZE-1:0] RST_VAL   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_a,
  input  logic [ADDR_W-1:0]    waddr_a,
  input  logic [WORD_SIZE-1:0] wdata_a,
  input  logic                 we_b,
  input  logic [ADDR_W-1:0]    waddr_b,
  input  logic [WORD_SIZE-1:0] wdata_b,
  input  logic [ADDR_W-1:0]    raddr_0,
  output logic [WORD_SIZE-1:0] rdata_0,
  input  logic [ADDR_W-1:0]    raddr_1,
  output logic [WORD_SIZE-1:0] rdata_1,
  output logic                 wr_conflict
);

  // One extra bit so NUM_REGS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] NUM_W = (ADDR_W+1)'(NUM_REGS);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ((ADDR_W+1)'(a) < NUM_W);
  endfunction

  logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
  logic                 wr_conflict_q;
  logic                 wr_conflict_d;
  logic                 valid_a;
  logic                 valid_b;
  logic [NUM_REGS-1:0]  hit_a;
  logic [NUM_REGS-1:0]  hit_b;

  assign valid_a = we_a && in_range(waddr_a);
  assign valid_b = we_b && in_range(waddr_b);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign hit_a[gi] = valid_a && (waddr_a == ADDR_W'(gi));
      assign hit_b[gi] = valid_b && (waddr_b == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= RST_VAL;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (hit_b[r])      regs_q[r] <= wdata_b;
        else if (hit_a[r]) regs_q[r] <= wdata_a;
      end
    end
  end

  assign wr_conflict_d = valid_a && valid_b && (waddr_a == waddr_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_conflict_q <= 1'b0;
    else     wr_conflict_q <= wr_conflict_d;
  end

  assign wr_conflict = wr_conflict_q;

  logic [ADDR_W-1:0] raddr_arr [2];
  assign raddr_arr[0] = raddr_0;
  assign raddr_arr[1] = raddr_1;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [WORD_SIZE-1:0] stored;
      logic [WORD_SIZE-1:0] rdata;

      always_comb begin
        stored = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
          if (raddr_arr[gi] == ADDR_W'(r)) stored = regs_q[r];
        end
      end

      // Forwarding uses the raw write enables; a matching valid read address
      // implies the write address is valid too.
      always_comb begin
        rdata = stored;
        if (BYPASS != 0 && !rst && in_range(raddr_arr[gi])) begin
          if (we_b && (waddr_b == raddr_arr[gi]))      rdata = wdata_b;
          else if (we_a && (waddr_a == raddr_arr[gi])) rdata = wdata_a;
        end
      end
    end
  endgenerate

  assign rdata_0 = g_rd[0].rdata;
  assign rdata_1 = g_rd[1].rdata;

endmodule

// File: tb/tb_reg_bank_2r2w.sv
// Scoreboard bench: two banks (forwarding off / on) share stimulus; a monitor
// compares their outputs each cycle against a queue filled by the stimulus.
module tb_reg_bank_2r2w;

  localparam int NREG = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_a = 1'b0, we_b = 1'b0;
  logic [3:0]  waddr_a = '0, waddr_b = '0, raddr_0 = '0, raddr_1 = '0;
  logic [15:0] wdata_a = '0, wdata_b = '0;
  logic [15:0] r0_nb, r1_nb, r0_bp, r1_bp;
  logic        conf_nb, conf_bp;

  always #5 clk = ~clk;

  reg_bank_2r2w #(.WORD_SIZE(16), .ADDR_W(4), .NUM_REGS(NREG), .BYPASS(0), .RST_VAL(16'h0000)) dut_nb (
    .clk(clk), .rst(rst),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr_0(raddr_0), .rdata_0(r0_nb),
    .raddr_1(raddr_1), .rdata_1(r1_nb),
    .wr_conflict(conf_nb)
  );

  reg_bank_2r2w #(.WORD_SIZE(16), .ADDR_W(4), .NUM_REGS(NREG), .BYPASS(1), .RST_VAL(16'h0000)) dut_bp (
    .clk(clk), .rst(rst),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr_0(raddr_0), .rdata_0(r0_bp),
    .raddr_1(raddr_1), .rdata_1(r1_bp),
    .wr_conflict(conf_bp)
  );

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] model [NREG];
  logic        model_conf = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] get_sig(input int s);
    case (s)
      0: return r0_nb;
      1: return r1_nb;
      2: return r0_bp;
      3: return r1_bp;
      4: return {15'b0, conf_nb};
      default: return {15'b0, conf_bp};
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      0: return "nb.rdata_0";
      1: return "nb.rdata_1";
      2: return "bp.rdata_0";
      3: return "bp.rdata_1";
      4: return "nb.wr_conflict";
      default: return "bp.wr_conflict";
    endcase
  endfunction

  // Monitor: outputs are stable mid-cycle; consume every entry for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [15:0] act;
      e = sb.pop_front();
      n_checks++;
      act = get_sig(e.sig);
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL stale %s cyc %0d: never sampled, required %h", sig_name(e.sig), e.cyc, e.exp);
      end else if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got %h required %h", sig_name(e.sig), e.cyc, act, e.exp);
      end
    end
  end

  function automatic logic [15:0] stored_rd(input logic [3:0] a);
    if (rst || a >= NREG) return 16'h0000;
    return model[a];
  endfunction

  function automatic logic [15:0] fwd_rd(input logic [3:0] a);
    if (!rst && a < NREG) begin
      if (we_b && waddr_b == a) return wdata_b;
      if (we_a && waddr_a == a) return wdata_a;
    end
    return stored_rd(a);
  endfunction

  task automatic push(input int s, input logic [15:0] v);
    exp_t e;
    e.cyc = cyc; e.sig = s; e.exp = v;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, queue expectations, then advance the model
  // across the next rising edge.
  task automatic step(input logic r,
                      input logic wa_en, input logic [3:0] wa, input logic [15:0] da,
                      input logic wb_en, input logic [3:0] wb, input logic [15:0] db,
                      input logic [3:0] ra0, input logic [3:0] ra1);
    rst = r;
    we_a = wa_en; waddr_a = wa; wdata_a = da;
    we_b = wb_en; waddr_b = wb; wdata_b = db;
    raddr_0 = ra0; raddr_1 = ra1;
    push(0, stored_rd(ra0));
    push(1, stored_rd(ra1));
    push(2, fwd_rd(ra0));
    push(3, fwd_rd(ra1));
    push(4, {15'b0, model_conf && !r});
    push(5, {15'b0, model_conf && !r});
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NREG; i++) model[i] = 16'h0000;
      model_conf = 1'b0;
    end else begin
      model_conf = wa_en && wb_en && wa == wb && wa < NREG;
      if (wa_en && wa < NREG) model[wa] = da;
      if (wb_en && wb < NREG) model[wb] = db;
    end
    #1;
  endtask

  task automatic idle(input logic [3:0] ra0, input logic [3:0] ra1);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, ra0, ra1);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) model[i] = 16'h0000;
    @(posedge clk); #1;
    step(1'b1, 1'b1, 4'd1, 16'hDEAD, 1'b1, 4'd1, 16'hDEAD, 4'd1, 4'd0);
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd1, 4'd0);
    // Load reg3, then assert reset mid-cycle and read it back at once.
    step(1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0, 4'd3, 4'd3);
    idle(4'd3, 4'd3);
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd3, 4'd3);
    idle(4'd3, 4'd3);
    step(1'b0, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0, 4'd5, 4'd5);
    idle(4'd5, 4'd5);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 16'hA5A5, 4'd7, 4'd7);
    idle(4'd7, 4'd7);
    step(1'b0, 1'b1, 4'd2, 16'h1111, 1'b1, 4'd2, 16'h2222, 4'd2, 4'd2);
    idle(4'd2, 4'd2);
    idle(4'd2, 4'd2);
    step(1'b0, 1'b1, 4'd13, 16'hFFFF, 1'b1, 4'd13, 16'hFFFF, 4'd13, 4'd13);
    for (int i = 0; i < NREG; i += 2) idle(4'(i), 4'(i + 1));
    step(1'b0, 1'b1, 4'd0, 16'h0001, 1'b1, 4'd11, 16'h8000, 4'd0, 4'd11);
    idle(4'd0, 4'd11);
    idle(4'd15, 4'd12);
    for (int n = 0; n < 400; n++) begin
      logic [3:0] a, b;
      a = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
      step($urandom_range(0, 39) == 0,
           1'($urandom), a, 16'($urandom),
           1'($urandom), b, 16'($urandom),
           ($urandom_range(0, 2) == 0) ? a : 4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0) ? b : 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < NREG; i += 2) idle(4'(i), 4'(i + 1));
    @(negedge clk); @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
